// File: rtl/servo_pkg.sv
// Shared constants for the servo PWM generator and decoder.
// Widths are in microseconds, which equals clk_1m ticks.
package servo_pkg;

    localparam int unsigned SERVO_PERIOD_US = 20000;
    localparam int unsigned SERVO_W_BITS    = 12;
    localparam int unsigned SERVO_GAP_BITS  = 15;

    localparam int unsigned SERVO_MIN_WIDTH = 500;
    localparam int unsigned SERVO_MAX_WIDTH = 2500;
    localparam int unsigned SERVO_TIMEOUT   = 25000;

    // Largest value a width counter can hold; counters stick here
    localparam logic [SERVO_W_BITS-1:0] SERVO_W_SAT = {SERVO_W_BITS{1'b1}};

    // True when a measured width lies inside the inclusive accept window
    function automatic logic servo_width_ok(
        input logic [SERVO_W_BITS-1:0] width,
        input logic [SERVO_W_BITS-1:0] lo,
        input logic [SERVO_W_BITS-1:0] hi
    );
        return (width >= lo) && (width <= hi);
    endfunction

endpackage

// File: rtl/servo_pwm_capture.sv
// Single-channel servo pulse capture: synchronizes one asynchronous pwm
// line, measures each high time in clk_1m ticks, and reports accepted
// widths, out-of-range pulses and loss of signal.
module servo_pwm_capture
    import servo_pkg::*;
#(
    parameter int unsigned MIN_WIDTH = SERVO_MIN_WIDTH,
    parameter int unsigned MAX_WIDTH = SERVO_MAX_WIDTH,
    parameter int unsigned TIMEOUT   = SERVO_TIMEOUT
) (
    input  logic                    clk_1m,
    input  logic                    rst,
    input  logic                    pwm_in,
    output logic [SERVO_W_BITS-1:0] width,
    output logic                    width_vld,
    output logic                    width_err,
    output logic                    lost
);

    localparam logic [SERVO_W_BITS-1:0]   MIN_W      = SERVO_W_BITS'(MIN_WIDTH);
    localparam logic [SERVO_W_BITS-1:0]   MAX_W      = SERVO_W_BITS'(MAX_WIDTH);
    localparam logic [SERVO_GAP_BITS-1:0] GAP_MAX    = SERVO_GAP_BITS'(TIMEOUT);
    localparam logic [SERVO_GAP_BITS-1:0] GAP_BEFORE = SERVO_GAP_BITS'(TIMEOUT - 1);

    logic                      sync1;
    logic                      sync2;
    logic                      prev;
    logic                      in_pulse;
    logic [SERVO_W_BITS-1:0]   hi_cnt;
    logic [SERVO_GAP_BITS-1:0] gap_cnt;

    logic rise;
    logic fall;
    logic pulse_end;
    logic pulse_ok;

    // Edges are taken from the synchronized level; prev holds last cycle's sync2
    assign rise      = sync2 & ~prev;
    assign fall      = ~sync2 & prev;
    assign pulse_end = fall & in_pulse;
    assign pulse_ok  = servo_width_ok(hi_cnt, MIN_W, MAX_W);

    // Two-stage synchronizer plus edge-history flop; all reset high so a line
    // already high at reset release is not mistaken for a new pulse
    always_ff @(posedge clk_1m) begin
        if (rst) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            prev  <= 1'b1;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    // High-time counter: restarts at 1 on a rise so N high cycles measure N
    always_ff @(posedge clk_1m) begin
        if (rst) begin
            in_pulse <= 1'b0;
            hi_cnt   <= '0;
        end else if (rise) begin
            in_pulse <= 1'b1;
            hi_cnt   <= SERVO_W_BITS'(1);
        end else begin
            if (sync2 && (hi_cnt != SERVO_W_SAT)) begin
                hi_cnt <= hi_cnt + SERVO_W_BITS'(1);
            end
            if (fall) begin
                in_pulse <= 1'b0;
            end
        end
    end

    // Publish the width or flag an error when a tracked pulse ends
    always_ff @(posedge clk_1m) begin
        if (rst) begin
            width     <= '0;
            width_vld <= 1'b0;
            width_err <= 1'b0;
        end else begin
            width_vld <= 1'b0;
            width_err <= 1'b0;
            if (pulse_end) begin
                if (pulse_ok) begin
                    width     <= hi_cnt;
                    width_vld <= 1'b1;
                end else begin
                    width_err <= 1'b1;
                end
            end
        end
    end

    // Time since last rise; lost sets when it reaches the limit and only a good pulse clears it
    always_ff @(posedge clk_1m) begin
        if (rst) begin
            gap_cnt <= '0;
            lost    <= 1'b1;
        end else begin
            if (rise) begin
                gap_cnt <= '0;
            end else if (gap_cnt != GAP_MAX) begin
                gap_cnt <= gap_cnt + SERVO_GAP_BITS'(1);
            end
            if (!rise && (gap_cnt == GAP_BEFORE)) begin
                lost <= 1'b1;
            end
            if (pulse_end && pulse_ok) begin
                lost <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/servo_pwm_decoder.sv
// Two-channel RC/servo pulse-width decoder. Each channel is an independent
// capture instance; this level only fans the channels out to the ports.
module servo_pwm_decoder
    import servo_pkg::*;
#(
    parameter int unsigned MIN_WIDTH = SERVO_MIN_WIDTH,
    parameter int unsigned MAX_WIDTH = SERVO_MAX_WIDTH,
    parameter int unsigned TIMEOUT   = SERVO_TIMEOUT
) (
    input  logic                    clk_1m,
    input  logic                    rst,
    input  logic [1:0]              pwm_in,
    output logic [SERVO_W_BITS-1:0] width0,
    output logic [SERVO_W_BITS-1:0] width1,
    output logic [1:0]              width_vld,
    output logic [1:0]              width_err,
    output logic [1:0]              lost
);

    logic [SERVO_W_BITS-1:0] width_ch [2];

    for (genvar g = 0; g < 2; g++) begin : g_chan
        servo_pwm_capture #(
            .MIN_WIDTH (MIN_WIDTH),
            .MAX_WIDTH (MAX_WIDTH),
            .TIMEOUT   (TIMEOUT)
        ) u_capture (
            .clk_1m    (clk_1m),
            .rst       (rst),
            .pwm_in    (pwm_in[g]),
            .width     (width_ch[g]),
            .width_vld (width_vld[g]),
            .width_err (width_err[g]),
            .lost      (lost[g])
        );
    end

    assign width0 = width_ch[0];
    assign width1 = width_ch[1];

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Testbench for servo_pwm_decoder: directed pulses with a scoreboard of
// expected strobes checked by an independent monitor.
`timescale 1ns/1ps
module tb_servo_pwm_decoder;

    logic        clk_1m = 1'b0;
    logic        rst;
    logic [1:0]  pwm_in;
    logic [11:0] width0;
    logic [11:0] width1;
    logic [1:0]  width_vld;
    logic [1:0]  width_err;
    logic [1:0]  lost;

    typedef struct {
        logic [1:0]  vld;
        logic [1:0]  err;
        logic [11:0] w0;
        logic [11:0] w1;
        int          cyc;
    } exp_t;

    exp_t        sb [$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [11:0] exp_w [2];
    int          rise_cyc [2];

    servo_pwm_decoder dut (
        .clk_1m    (clk_1m),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .width0    (width0),
        .width1    (width1),
        .width_vld (width_vld),
        .width_err (width_err),
        .lost      (lost)
    );

    // 1 MHz nominal clock (period scaled to 10 ns) and a rising-edge counter
    always #5 clk_1m = ~clk_1m;

    always @(posedge clk_1m) cyc = cyc + 1;

    // Compare one value and record the result
    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected=%0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Drive pulses of w0/w1 high cycles that fall on the same cycle (0 = idle),
    // and queue the strobe the decoder should produce 3 edges after the fall
    task automatic applyStimulus(input int w0, input int w1);
        int   w [2];
        int   wmax;
        exp_t e;
        w[0] = w0;
        w[1] = w1;
        wmax = (w0 > w1) ? w0 : w1;
        for (int i = 0; i < wmax; i++) begin
            @(negedge clk_1m);
            for (int ch = 0; ch < 2; ch++) begin
                if (w[ch] > 0 && i >= wmax - w[ch]) begin
                    if (i == wmax - w[ch]) rise_cyc[ch] = cyc;
                    pwm_in[ch] = 1'b1;
                end
            end
        end
        @(negedge clk_1m);
        e.vld = 2'b00;
        e.err = 2'b00;
        for (int ch = 0; ch < 2; ch++) begin
            if (w[ch] > 0) begin
                if (w[ch] >= 500 && w[ch] <= 2500) begin
                    e.vld[ch] = 1'b1;
                    exp_w[ch] = 12'(w[ch]);
                end else begin
                    e.err[ch] = 1'b1;
                end
            end
        end
        e.w0  = exp_w[0];
        e.w1  = exp_w[1];
        e.cyc = cyc + 3;
        sb.push_back(e);
        pwm_in = 2'b00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_1m);
    endtask

    // Monitor: every strobe must match the oldest queued expectation
    always @(negedge clk_1m) begin
        if (width_vld != 2'b00 || width_err != 2'b00) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_strobe actual vld=%b err=%b required none (cycle %0d)",
                         width_vld, width_err, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("strobe_vld",   int'(width_vld), int'(e.vld));
                checkOutput("strobe_err",   int'(width_err), int'(e.err));
                checkOutput("strobe_w0",    int'(width0),    int'(e.w0));
                checkOutput("strobe_w1",    int'(width1),    int'(e.w1));
                checkOutput("strobe_cycle", cyc,             e.cyc);
            end
        end
    end

    // Hard bound on the run in case the stimulus ever stalls
    initial begin
        #1_500_000;
        $display("[TB] FAIL watchdog expired actual=running required=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int r;
        rst       = 1'b1;
        pwm_in    = 2'b00;
        exp_w[0]  = '0;
        exp_w[1]  = '0;
        idle(3);
        checkOutput("reset_width0", int'(width0),    0);
        checkOutput("reset_width1", int'(width1),    0);
        checkOutput("reset_vld",    int'(width_vld), 0);
        checkOutput("reset_err",    int'(width_err), 0);
        checkOutput("reset_lost",   int'(lost),      3);
        rst = 1'b0;
        idle(5);

        $display("[TB] test 1: single 1500 us pulse");
        checkOutput("t1_lost0_before", int'(lost[0]), 1);
        applyStimulus(1500, 0);
        idle(10);
        checkOutput("t1_width0", int'(width0), 1500);
        checkOutput("t1_lost0_after", int'(lost[0]), 0);

        $display("[TB] test 2: short and over-long pulses");
        applyStimulus(400, 0);
        idle(10);
        applyStimulus(5000, 0);
        idle(10);
        checkOutput("t2_width0_kept", int'(width0), 1500);

        $display("[TB] test 3: range boundaries");
        applyStimulus(500, 0);
        idle(10);
        applyStimulus(2500, 0);
        idle(10);
        applyStimulus(499, 0);
        idle(10);
        applyStimulus(2501, 0);
        idle(10);
        checkOutput("t3_width0", int'(width0), 2500);

        $display("[TB] test 6: simultaneous falls on both channels");
        applyStimulus(1000, 2000);
        idle(10);
        checkOutput("t6_width0", int'(width0), 1000);
        checkOutput("t6_width1", int'(width1), 2000);

        $display("[TB] test 4: loss of signal timeout");
        applyStimulus(1500, 0);
        r = rise_cyc[0];
        while (cyc < r + 19999) @(negedge clk_1m);
        checkOutput("t4_lost0_mid", int'(lost[0]), 0);
        applyStimulus(1500, 0);
        r = rise_cyc[0];
        // two synchronizer edges, one edge to register the rise, then TIMEOUT edges
        while (cyc < r + 25002) @(negedge clk_1m);
        checkOutput("t4_lost0_just_before", int'(lost[0]), 0);
        @(negedge clk_1m);
        checkOutput("t4_lost0_at_timeout", int'(lost[0]), 1);
        idle(10);
        applyStimulus(1500, 0);
        idle(10);
        checkOutput("t4_lost0_cleared", int'(lost[0]), 0);

        $display("[TB] test 5: reset in the middle of a pulse");
        @(negedge clk_1m);
        pwm_in[0] = 1'b1;
        idle(700);
        rst      = 1'b1;
        exp_w[0] = '0;
        exp_w[1] = '0;
        idle(2);
        checkOutput("t5_reset_width0", int'(width0), 0);
        checkOutput("t5_reset_lost",   int'(lost),   3);
        rst = 1'b0;
        idle(300);
        pwm_in[0] = 1'b0;
        idle(20);
        checkOutput("t5_width0_after_partial", int'(width0), 0);
        applyStimulus(1200, 0);
        idle(10);
        checkOutput("t5_width0", int'(width0), 1200);

        idle(10);
        checkOutput("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
